// File: rtl/xbar_rr_parthi.sv
// Registered N_IN x N_OUT crossbar: per-output round-robin arbiter feeding a one-entry
// valid/ready output register; words addressed beyond the last output are dropped and counted.
module xbar_rr_parthi #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int DW    = 8,
  parameter int SELW  = 2,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*DW-1:0]    in_data,
  input  logic [N_IN*SELW-1:0]  in_dest,
  output logic [N_IN-1:0]       in_ready,
  output logic [N_OUT-1:0]      out_valid,
  output logic [N_OUT*DW-1:0]   out_data,
  output logic [N_OUT*IDW-1:0]  out_src,
  input  logic [N_OUT-1:0]      out_ready,
  output logic [7:0]            drop_cnt
);

  localparam int CNTW = $clog2(N_IN + 1) + 9;
  localparam logic [SELW:0] N_OUT_L = (SELW+1)'(N_OUT);

  logic [SELW-1:0]              dest [N_IN];
  logic [DW-1:0]                data [N_IN];
  logic [N_IN-1:0]              dest_bad;
  logic [N_OUT-1:0][N_IN-1:0]   req;
  logic [N_OUT-1:0]             gnt_vld;
  logic [N_OUT-1:0]             can_load;
  logic [N_OUT-1:0]             load;
  logic [IDW-1:0]               gnt_idx [N_OUT];
  logic [IDW-1:0]               idx;
  logic [IDW-1:0]               rr_ptr_q [N_OUT];
  logic [IDW-1:0]               rr_ptr_d [N_OUT];
  logic [N_OUT-1:0]             out_valid_q;
  logic [DW-1:0]                out_data_q [N_OUT];
  logic [IDW-1:0]               out_src_q [N_OUT];
  logic [7:0]                   drop_cnt_q;
  logic [7:0]                   drop_cnt_d;
  logic [CNTW-1:0]              drop_sum;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_in
      assign dest[gi]     = in_dest[gi*SELW +: SELW];
      assign data[gi]     = in_data[gi*DW +: DW];
      assign dest_bad[gi] = in_valid[gi] & ({1'b0, dest[gi]} >= N_OUT_L);
    end
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
      assign out_valid[gi]            = out_valid_q[gi];
      assign out_data[gi*DW +: DW]    = out_data_q[gi];
      assign out_src[gi*IDW +: IDW]   = out_src_q[gi];
    end
  endgenerate

  assign drop_cnt = drop_cnt_q;

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        req[j][i] = in_valid[i] & ~dest_bad[i] & (dest[i] == SELW'(j));
      end
    end
  end

  // Grants depend only on requests, pointers and output state, never on in_ready itself.
  always_comb begin
    can_load = ~out_valid_q | out_ready;
    gnt_vld  = '0;
    load     = '0;
    in_ready = dest_bad;
    idx      = '0;
    for (int j = 0; j < N_OUT; j++) begin
      gnt_idx[j]  = '0;
      rr_ptr_d[j] = rr_ptr_q[j];
      for (int k = 0; k < N_IN; k++) begin
        idx = IDW'((int'(rr_ptr_q[j]) + k) % N_IN);
        if (!gnt_vld[j] && req[j][idx]) begin
          gnt_vld[j] = 1'b1;
          gnt_idx[j] = idx;
        end
      end
      load[j] = gnt_vld[j] & can_load[j];
      if (load[j]) begin
        in_ready[gnt_idx[j]] = 1'b1;
        rr_ptr_d[j]          = IDW'((int'(gnt_idx[j]) + 1) % N_IN);
      end
    end

    drop_sum = CNTW'(drop_cnt_q);
    for (int i = 0; i < N_IN; i++) begin
      drop_sum = drop_sum + CNTW'(dest_bad[i]);
    end
    drop_cnt_d = (drop_sum > CNTW'(255)) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      drop_cnt_q  <= '0;
      for (int j = 0; j < N_OUT; j++) begin
        rr_ptr_q[j]   <= '0;
        out_data_q[j] <= '0;
        out_src_q[j]  <= '0;
      end
    end else begin
      drop_cnt_q <= drop_cnt_d;
      for (int j = 0; j < N_OUT; j++) begin
        rr_ptr_q[j] <= rr_ptr_d[j];
        if (load[j]) begin
          out_valid_q[j] <= 1'b1;
          out_data_q[j]  <= data[gnt_idx[j]];
          out_src_q[j]   <= gnt_idx[j];
        end else if (out_ready[j]) begin
          out_valid_q[j] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_xbar_rr_parthi.sv
// Directed bench for xbar_rr_parthi: stimulus pushes expected words per output,
// a negedge monitor pops and compares each word the DUT hands to its sink.
module tb_xbar_rr_parthi;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [11:0] in_dest;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [7:0]  out_src;
  logic [3:0]  out_ready;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q [4][$];
  logic [9:0] mon_e;

  xbar_rr_parthi #(.N_IN(4), .N_OUT(4), .DW(8), .SELW(3), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [7:0] d, input logic [2:0] ds);
    in_valid[i]        = v;
    in_data[i*8 +: 8]  = d;
    in_dest[i*3 +: 3]  = ds;
  endtask

  task automatic push(input int j, input logic [7:0] d, input logic [1:0] s);
    exp_q[j].push_back({d, s});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < 4; j++) begin
        if (out_valid[j] && out_ready[j]) begin
          if (exp_q[j].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out%0d_unexpected: got data=0x%02h src=%0d, required no word",
                     j, out_data[j*8 +: 8], out_src[j*2 +: 2]);
          end else begin
            mon_e = exp_q[j].pop_front();
            $display("out%0d word data=0x%02h src=%0d", j, out_data[j*8 +: 8], out_src[j*2 +: 2]);
            chk($sformatf("out%0d_data", j), 32'(out_data[j*8 +: 8]), 32'(mon_e[9:2]));
            chk($sformatf("out%0d_src", j), 32'(out_src[j*2 +: 2]), 32'(mon_e[1:0]));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; in_dest = '0; out_ready = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);

    // Reset mid-traffic
    rst = 1'b0;
    drive(2, 1'b1, 8'h77, 3'd3);
    drive(0, 1'b1, 8'hEE, 3'd6);
    #1;
    chk("t1_in_ready", 32'(in_ready), 32'h5);
    step();
    chk("t1_out_valid", 32'(out_valid), 32'h8);
    chk("t1_out3_data", 32'(out_data[31:24]), 32'h77);
    chk("t1_drop_cnt", 32'(drop_cnt), 32'h1);
    rst = 1'b1;
    #1;
    chk("t1_async_valid", 32'(out_valid), 32'h0);
    chk("t1_async_drop", 32'(drop_cnt), 32'h0);
    chk("t1_async_data", out_data, 32'h0);
    for (int j = 0; j < 4; j++) exp_q[j].delete();
    drive(0, 1'b0, 8'h00, 3'd0);
    drive(2, 1'b0, 8'h00, 3'd0);
    drive(1, 1'b1, 8'h31, 3'd0);
    drive(3, 1'b1, 8'h33, 3'd0);
    step();
    rst = 1'b0;
    #1;
    chk("t1_first_grant", 32'(in_ready), 32'h2);
    push(0, 8'h31, 2'd1);
    step();
    drive(1, 1'b0, 8'h00, 3'd0);
    #1;
    chk("t1_second_grant", 32'(in_ready), 32'h8);
    push(0, 8'h33, 2'd3);
    step();
    drive(3, 1'b0, 8'h00, 3'd0);

    // Single path
    drive(0, 1'b1, 8'hA5, 3'd2);
    #1;
    chk("t2_in_ready", 32'(in_ready), 32'h1);
    push(2, 8'hA5, 2'd0);
    step();
    drive(0, 1'b0, 8'h00, 3'd0);
    chk("t2_out_valid", 32'(out_valid), 32'h4);
    chk("t2_out2_data", 32'(out_data[23:16]), 32'hA5);
    chk("t2_out2_src", 32'(out_src[5:4]), 32'h0);

    // Round robin, all inputs to out1
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 8'(8'h10 + i), 3'd1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t3_grant%0d", k), 32'(in_ready), 32'(1 << (k % 4)));
      push(1, 8'(8'h10 + (k % 4)), 2'(k % 4));
      step();
    end
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 8'h00, 3'd0);

    // Backpressure on out3
    out_ready[3] = 1'b0;
    drive(0, 1'b1, 8'hC0, 3'd3);
    #1;
    chk("t4_first_load", 32'(in_ready), 32'h1);
    push(3, 8'hC0, 2'd0);
    step();
    drive(0, 1'b1, 8'hC1, 3'd3);
    drive(1, 1'b1, 8'hD1, 3'd3);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t4_stall_rdy%0d", k), 32'(in_ready), 32'h0);
      chk($sformatf("t4_stall_data%0d", k), 32'(out_data[31:24]), 32'hC0);
      chk($sformatf("t4_stall_valid%0d", k), 32'(out_valid[3]), 32'h1);
      step();
    end
    out_ready[3] = 1'b1;
    #1;
    chk("t4_release_rdy", 32'(in_ready), 32'h2);
    push(3, 8'hD1, 2'd1);
    step();
    drive(1, 1'b0, 8'h00, 3'd0);
    #1;
    chk("t4_reload_data", 32'(out_data[31:24]), 32'hD1);
    chk("t4_next_rdy", 32'(in_ready), 32'h1);
    push(3, 8'hC1, 2'd0);
    step();
    drive(0, 1'b0, 8'h00, 3'd0);

    // Parallel loads plus a drop, then saturation
    drive(0, 1'b1, 8'h50, 3'd0);
    drive(1, 1'b1, 8'h51, 3'd1);
    drive(2, 1'b1, 8'h52, 3'd5);
    #1;
    chk("t5_in_ready", 32'(in_ready), 32'h7);
    push(0, 8'h50, 2'd0);
    push(1, 8'h51, 2'd1);
    step();
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 8'h00, 3'd0);
    chk("t5_drop1", 32'(drop_cnt), 32'h1);
    chk("t5_out_valid", 32'(out_valid), 32'h3);
    drive(0, 1'b1, 8'h00, 3'd7);
    drive(1, 1'b1, 8'h00, 3'd6);
    drive(3, 1'b1, 8'h00, 3'd4);
    step();
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 8'h00, 3'd0);
    chk("t5_drop_multi", 32'(drop_cnt), 32'd4);
    drive(2, 1'b1, 8'h52, 3'd5);
    repeat (249) step();
    chk("t5_drop_253", 32'(drop_cnt), 32'd253);
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 8'h00, 3'd5);
    #1;
    chk("t5_all_drop_rdy", 32'(in_ready), 32'hF);
    step();
    chk("t5_drop_sat", 32'(drop_cnt), 32'd255);
    drive(0, 1'b0, 8'h00, 3'd0);
    drive(1, 1'b0, 8'h00, 3'd0);
    drive(3, 1'b0, 8'h00, 3'd0);
    repeat (50) step();
    chk("t5_drop_hold", 32'(drop_cnt), 32'd255);
    drive(2, 1'b0, 8'h00, 3'd0);

    repeat (3) step();
    for (int j = 0; j < 4; j++) chk($sformatf("out%0d_pending", j), 32'(exp_q[j].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
